// File: rtl/usb_ctrl_in_tx.sv
// EP0 control-IN data-stage transmitter: streams a descriptor from byte memory into the usbcorev core.
// Build option USB_CTRL_IN_STALL_EN: a request with desc_len == 0 is answered with STALL instead of a ZLP.
module usb_ctrl_in_tx #(
    parameter int MAX_PKT = 64,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 16
) (
    input  logic              clk48mhz,
    input  logic              rst,
    input  logic              usb_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] desc_base,
    input  logic [LEN_W-1:0]  desc_len,
    input  logic [LEN_W-1:0]  w_length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic [3:0]        endpoint,
    input  logic              transaction_active,
    input  logic              direction_in,
    input  logic              setup,
    input  logic              data_strobe,
    input  logic              success,
    output logic [7:0]        data_in,
    output logic              data_in_valid,
    output logic              data_toggle,
    output logic [1:0]        handshake,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(MAX_PKT) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SEND, S_COMMIT, S_STALLED} state_t;
    state_t state, state_n;

    logic              rst_any;
    logic              ta_q, strobe_q;
    logic              ta_rise, ta_fall, strobe_rise, in_tok, setup_tok;
    logic [ADDR_W-1:0] ptr, pkt_ptr;
    logic [LEN_W-1:0]  remaining, pkt_rem;
    logic [CNT_W-1:0]  pkt_cnt;
    logic              total_eq, ok_q, commit_ok, finish, stall_req;
    logic [1:0]        age;

    assign rst_any     = rst | usb_rst;
    assign ta_rise     = transaction_active & ~ta_q;
    assign ta_fall     = ~transaction_active & ta_q;
    assign strobe_rise = data_strobe & ~strobe_q;
    assign setup_tok   = ta_rise & setup & (endpoint == 4'd0);
    assign in_tok      = ta_rise & ~setup & direction_in & (endpoint == 4'd0);
    assign commit_ok   = ok_q | success;
    assign finish      = commit_ok &&
                         ((pkt_cnt < CNT_W'(MAX_PKT)) || ((pkt_rem == '0) && total_eq));
    assign mem_addr    = ptr;

`ifdef USB_CTRL_IN_STALL_EN
    assign stall_req = (desc_len == '0);
`else
    assign stall_req = 1'b0;
`endif

    always_ff @(posedge clk48mhz) begin
        if (rst_any) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n       = state;
        handshake     = 2'b00;
        data_in_valid = 1'b0;
        busy          = 1'b1;
        case (state)
            S_IDLE: begin
                handshake = 2'b10;
                busy      = 1'b0;
                if (start) state_n = stall_req ? S_STALLED : S_ARMED;
            end
            S_ARMED: begin
                if (setup_tok)   state_n = S_IDLE;
                else if (in_tok) state_n = S_SEND;
            end
            S_SEND: begin
                // age==2 means data_in already reflects the byte at the current ptr
                data_in_valid = (age == 2'd2) && (pkt_cnt < CNT_W'(MAX_PKT)) && (pkt_rem != '0);
                if (setup_tok)    state_n = S_IDLE;
                else if (ta_fall) state_n = S_COMMIT;
            end
            S_COMMIT: begin
                if (setup_tok)   state_n = S_IDLE;
                else if (finish) state_n = S_IDLE;
                else             state_n = S_ARMED;
            end
            S_STALLED: begin
                handshake = 2'b11;
                if (setup_tok) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk48mhz) begin
        ta_q     <= transaction_active;
        strobe_q <= data_strobe;
        done     <= 1'b0;
        if (state != S_IDLE) data_in <= mem_data;
        if (age != 2'd2) age <= age + 2'd1;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ptr         <= desc_base;
                    remaining   <= (desc_len < w_length) ? desc_len : w_length;
                    total_eq    <= (desc_len >= w_length);
                    data_toggle <= 1'b1;
                    age         <= 2'd0;
                end
            end
            S_ARMED: begin
                if (in_tok) begin
                    pkt_ptr <= ptr;
                    pkt_rem <= remaining;
                    pkt_cnt <= '0;
                    ok_q    <= 1'b0;
                end
            end
            S_SEND: begin
                if (success) ok_q <= 1'b1;
                if (strobe_rise && data_in_valid) begin
                    ptr     <= ptr + ADDR_W'(1);
                    pkt_rem <= pkt_rem - LEN_W'(1);
                    pkt_cnt <= pkt_cnt + CNT_W'(1);
                    age     <= 2'd0;
                end
            end
            S_COMMIT: begin
                if (!setup_tok) begin
                    if (commit_ok) begin
                        remaining   <= pkt_rem;
                        data_toggle <= ~data_toggle;
                    end else begin
                        // host did not ACK: rewind so the same packet is offered again
                        ptr <= pkt_ptr;
                        age <= 2'd0;
                    end
                    done <= finish;
                end
            end
            default: ;
        endcase
        if (rst_any) begin
            ptr         <= '0;
            data_in     <= 8'd0;
            data_toggle <= 1'b0;
            done        <= 1'b0;
            ta_q        <= 1'b0;
            strobe_q    <= 1'b0;
            ok_q        <= 1'b0;
            age         <= 2'd0;
        end
    end

endmodule
